// File: rtl/spi_slave_base.sv
// SPI slave, modes 0..3, fully oversampled by clk: SPCK/MOSI/CS_n are synchronized,
// SPCK edges are detected in the clk domain, and one byte is exchanged per 8 SPCK cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | chip select high; SPCK edges ignored, MISO undriven
// ACTIVE  | chip select low; bytes shifted in on sample edges, out on shift edges
module spi_slave_base #(
   parameter int SPI_MODE = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_En,
   output logic       o_TX_Ready,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_En,
   input  logic       i_SPCK,
   input  logic       i_MOSI,
   input  logic       i_CS_n,
   output logic       o_MISO,
   output logic       o_MISO_En
);

   localparam logic CPOL = (SPI_MODE >= 2);
   localparam logic CPHA = ((SPI_MODE % 2) == 1);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   state_t     r_state;
   state_t     w_state_next;

   logic       r_spck_meta;
   logic       r_spck_sync;
   logic       r_spck_prev;
   logic       r_mosi_meta;
   logic       r_mosi_sync;
   logic       r_cs_meta;
   logic       r_cs_sync;

   logic [7:0] r_rx_shift;
   logic [2:0] r_rx_cnt;
   logic [7:0] r_tx_shift;
   logic [2:0] r_tx_cnt;
   logic [7:0] r_tx_hold;
   logic       r_tx_full;

   logic       w_lead;
   logic       w_trail;
   logic       w_start;
   logic       w_stop;
   logic       w_sample;
   logic       w_shift;
   logic       w_reload;
   logic [7:0] w_reload_byte;

   // Synchronizers preset to the idle bus so reset release never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spck_meta <= CPOL;
         r_spck_sync <= CPOL;
         r_spck_prev <= CPOL;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
      end else begin
         r_spck_meta <= i_SPCK;
         r_spck_sync <= r_spck_meta;
         r_spck_prev <= r_spck_sync;
         r_mosi_meta <= i_MOSI;
         r_mosi_sync <= r_mosi_meta;
         r_cs_meta   <= i_CS_n;
         r_cs_sync   <= r_cs_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_stop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!r_cs_sync) begin
               w_state_next = ST_ACTIVE;
               w_start      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (r_cs_sync) begin
               w_state_next = ST_IDLE;
               w_stop       = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_lead   = (r_spck_sync != r_spck_prev) && (r_spck_sync != CPOL);
      w_trail  = (r_spck_sync != r_spck_prev) && (r_spck_sync == CPOL);
      w_sample = (r_state == ST_ACTIVE) && (CPHA ? w_trail : w_lead);
      w_shift  = (r_state == ST_ACTIVE) && !w_stop && (CPHA ? w_lead : w_trail);
      // Next-byte boundary: counter back at 7, or chip-select fall when CPHA=0.
      w_reload = (w_shift && (r_tx_cnt == 3'd7)) || (w_start && !CPHA);
      if (i_TX_En)        w_reload_byte = i_TX_Byte;
      else if (r_tx_full) w_reload_byte = r_tx_hold;
      else                w_reload_byte = 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_hold <= 8'h00;
         r_tx_full <= 1'b0;
      end else if (w_reload && !i_TX_En && r_tx_full) begin
         r_tx_full <= 1'b0;
      end else if (i_TX_En && !w_reload) begin
         r_tx_hold <= i_TX_Byte;
         r_tx_full <= 1'b1;
      end
   end

   assign o_TX_Ready = ~r_tx_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_shift <= 8'h00;
         r_rx_cnt   <= 3'd7;
         r_tx_shift <= 8'h00;
         r_tx_cnt   <= 3'd7;
         o_RX_Byte  <= 8'h00;
         o_RX_En    <= 1'b0;
         o_MISO     <= 1'b0;
         o_MISO_En  <= 1'b0;
      end else begin
         o_RX_En <= 1'b0;
         if (w_sample) begin
            r_rx_shift <= {r_rx_shift[6:0], r_mosi_sync};
            r_rx_cnt   <= r_rx_cnt - 3'd1;
            if (r_rx_cnt == 3'd0) begin
               o_RX_Byte <= {r_rx_shift[6:0], r_mosi_sync};
               o_RX_En   <= 1'b1;
            end
         end
         // A stop in the same clk as the final sample still lets the byte complete above.
         if (w_start) begin
            r_rx_cnt  <= 3'd7;
            o_MISO_En <= 1'b1;
            if (CPHA) begin
               r_tx_cnt <= 3'd7;
            end else begin
               r_tx_cnt   <= 3'd6;
               o_MISO     <= w_reload_byte[7];
               r_tx_shift <= {w_reload_byte[6:0], 1'b0};
            end
         end else if (w_stop) begin
            r_rx_cnt   <= 3'd7;
            r_rx_shift <= 8'h00;
            r_tx_cnt   <= 3'd7;
            r_tx_shift <= 8'h00;
            o_MISO     <= 1'b0;
            o_MISO_En  <= 1'b0;
         end else if (w_shift) begin
            r_tx_cnt <= r_tx_cnt - 3'd1;
            if (w_reload) begin
               o_MISO     <= w_reload_byte[7];
               r_tx_shift <= {w_reload_byte[6:0], 1'b0};
            end else begin
               o_MISO     <= r_tx_shift[7];
               r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_base.sv
// Directed bench for spi_slave_base: one instance per SPI mode, a bit-banged master
// at SPCK = clk/8, and immediate assertions against hand-computed bytes.
module tb_spi_slave_base;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] spck;
   logic [3:0] mosi;
   logic [3:0] cs_n;
   logic [3:0] tx_en;
   logic [7:0] tx_byte [4];
   wire  [3:0] tx_ready;
   wire  [3:0] rx_en;
   wire  [3:0] miso;
   wire  [3:0] miso_en;
   wire  [7:0] rx_byte [4];

   int n_checks = 0;
   int n_fail   = 0;
   int rx_pulses [4] = '{default: 0};

   always #5 clk = ~clk;

   spi_slave_base #(.SPI_MODE(0)) u_m0 (
      .clk(clk), .rst_n(rst_n), .i_TX_Byte(tx_byte[0]), .i_TX_En(tx_en[0]),
      .o_TX_Ready(tx_ready[0]), .o_RX_Byte(rx_byte[0]), .o_RX_En(rx_en[0]),
      .i_SPCK(spck[0]), .i_MOSI(mosi[0]), .i_CS_n(cs_n[0]),
      .o_MISO(miso[0]), .o_MISO_En(miso_en[0]));
   spi_slave_base #(.SPI_MODE(1)) u_m1 (
      .clk(clk), .rst_n(rst_n), .i_TX_Byte(tx_byte[1]), .i_TX_En(tx_en[1]),
      .o_TX_Ready(tx_ready[1]), .o_RX_Byte(rx_byte[1]), .o_RX_En(rx_en[1]),
      .i_SPCK(spck[1]), .i_MOSI(mosi[1]), .i_CS_n(cs_n[1]),
      .o_MISO(miso[1]), .o_MISO_En(miso_en[1]));
   spi_slave_base #(.SPI_MODE(2)) u_m2 (
      .clk(clk), .rst_n(rst_n), .i_TX_Byte(tx_byte[2]), .i_TX_En(tx_en[2]),
      .o_TX_Ready(tx_ready[2]), .o_RX_Byte(rx_byte[2]), .o_RX_En(rx_en[2]),
      .i_SPCK(spck[2]), .i_MOSI(mosi[2]), .i_CS_n(cs_n[2]),
      .o_MISO(miso[2]), .o_MISO_En(miso_en[2]));
   spi_slave_base #(.SPI_MODE(3)) u_m3 (
      .clk(clk), .rst_n(rst_n), .i_TX_Byte(tx_byte[3]), .i_TX_En(tx_en[3]),
      .o_TX_Ready(tx_ready[3]), .o_RX_Byte(rx_byte[3]), .o_RX_En(rx_en[3]),
      .i_SPCK(spck[3]), .i_MOSI(mosi[3]), .i_CS_n(cs_n[3]),
      .o_MISO(miso[3]), .o_MISO_En(miso_en[3]));

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++)
         if (rx_en[k] === 1'b1) rx_pulses[k]++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_load(input int m, input logic [7:0] b);
      tx_byte[m] = b;
      tx_en[m]   = 1'b1;
      @(negedge clk);
      tx_en[m]   = 1'b0;
   endtask

   task automatic cs_begin(input int m);
      cs_n[m] = 1'b0;
      clks(8);
   endtask

   task automatic cs_end(input int m);
      clks(4);
      cs_n[m] = 1'b1;
      clks(8);
   endtask

   // Master: drives mo MSB first and returns what it captured from MISO.
   task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      logic cpol;
      logic cpha;
      cpol = (m >= 2);
      cpha = ((m % 2) == 1);
      mi   = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            mosi[m] = mo[i];
            clks(4);
            mi[i]   = miso[m];
            spck[m] = ~cpol;
            clks(4);
            spck[m] = cpol;
         end else begin
            spck[m] = ~cpol;
            mosi[m] = mo[i];
            clks(4);
            mi[i]   = miso[m];
            spck[m] = cpol;
            clks(4);
         end
      end
   endtask

   initial begin
      logic [7:0] mi;
      logic [7:0] mi2;
      int         p;

      rst_n = 1'b0;
      spck  = 4'b1100;
      mosi  = 4'b0000;
      cs_n  = 4'b1111;
      tx_en = 4'b0000;
      for (int k = 0; k < 4; k++) tx_byte[k] = 8'h00;
      clks(3);
      chk("rst_rx_byte",  rx_byte[0], 8'h00);
      chk("rst_rx_en",    8'(rx_en[0]), 8'h00);
      chk("rst_miso",     8'(miso[0]), 8'h00);
      chk("rst_miso_en",  8'(miso_en[0]), 8'h00);
      chk("rst_tx_ready", 8'(tx_ready[0]), 8'h01);
      rst_n = 1'b1;
      clks(4);

      // Single-byte exchange in every mode.
      for (int m = 0; m < 4; m++) begin
         tx_load(m, 8'hA5);
         chk($sformatf("m%0d_tx_ready_low", m), 8'(tx_ready[m]), 8'h00);
         p = rx_pulses[m];
         cs_begin(m);
         chk($sformatf("m%0d_miso_en_on", m), 8'(miso_en[m]), 8'h01);
         xfer(m, 8'h3C, 8, mi);
         cs_end(m);
         chk($sformatf("m%0d_rx_byte", m), rx_byte[m], 8'h3C);
         chk($sformatf("m%0d_rx_pulses", m), 8'(rx_pulses[m] - p), 8'h01);
         chk($sformatf("m%0d_master_rx", m), mi, 8'hA5);
         chk($sformatf("m%0d_tx_ready_high", m), 8'(tx_ready[m]), 8'h01);
         chk($sformatf("m%0d_miso_en_off", m), 8'(miso_en[m]), 8'h00);
      end

      // Two bytes in one window, only one queued: second byte underruns.
      tx_load(0, 8'h11);
      p = rx_pulses[0];
      cs_begin(0);
      xfer(0, 8'h5A, 8, mi);
      xfer(0, 8'h96, 8, mi2);
      cs_end(0);
      chk("two_master_b0", mi, 8'h11);
      chk("two_master_b1", mi2, 8'h00);
      chk("two_rx_pulses", 8'(rx_pulses[0] - p), 8'h02);
      chk("two_rx_byte", rx_byte[0], 8'h96);

      // Abort after 5 bits (mode 3), then a clean byte.
      tx_load(3, 8'hFF);
      p = rx_pulses[3];
      cs_begin(3);
      xfer(3, 8'hFF, 5, mi);
      chk("part_miso_driven", 8'(miso[3]), 8'h01);
      cs_end(3);
      chk("part_no_rx_en", 8'(rx_pulses[3] - p), 8'h00);
      chk("part_miso_en", 8'(miso_en[3]), 8'h00);
      chk("part_miso", 8'(miso[3]), 8'h00);
      cs_begin(3);
      xfer(3, 8'hC3, 8, mi);
      cs_end(3);
      chk("part_next_rx", rx_byte[3], 8'hC3);
      chk("part_next_pulses", 8'(rx_pulses[3] - p), 8'h01);

      // Last write to the holding register wins (mode 2).
      tx_load(2, 8'h01);
      tx_load(2, 8'h02);
      cs_begin(2);
      xfer(2, 8'h77, 8, mi);
      cs_end(2);
      chk("ovw_master_rx", mi, 8'h02);
      chk("ovw_rx_byte", rx_byte[2], 8'h77);

      // Reset mid-byte (mode 0) with the holding register refilled.
      tx_load(0, 8'hFF);
      cs_begin(0);
      xfer(0, 8'hF0, 3, mi);
      tx_load(0, 8'h3D);
      chk("mid_miso_en", 8'(miso_en[0]), 8'h01);
      chk("mid_tx_ready", 8'(tx_ready[0]), 8'h00);
      rst_n = 1'b0;
      #1;
      chk("arst_rx_byte",  rx_byte[0], 8'h00);
      chk("arst_rx_en",    8'(rx_en[0]), 8'h00);
      chk("arst_miso",     8'(miso[0]), 8'h00);
      chk("arst_miso_en",  8'(miso_en[0]), 8'h00);
      chk("arst_tx_ready", 8'(tx_ready[0]), 8'h01);
      cs_n[0] = 1'b1;
      spck[0] = 1'b0;
      mosi[0] = 1'b0;
      clks(2);
      rst_n = 1'b1;
      clks(4);
      tx_load(0, 8'h5C);
      p = rx_pulses[0];
      cs_begin(0);
      xfer(0, 8'h81, 8, mi);
      cs_end(0);
      chk("post_rst_master_rx", mi, 8'h5C);
      chk("post_rst_rx_byte", rx_byte[0], 8'h81);
      chk("post_rst_pulses", 8'(rx_pulses[0] - p), 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
